// File: rtl/cpu_mem_pkg.sv
// Shared address map, region type and decoder for the cpu data-memory path.
package cpu_mem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR = 15'h6000;
    localparam logic [ADDR_W-1:0] SWR_ADDR = 15'h6001;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCR,
        REG_KBD,
        REG_SWR,
        REG_NONE
    } region_e;

    // Classify a data address; region sizes are passed in so the map follows the top parameters.
    function automatic region_e decode_addr(input logic [ADDR_W-1:0] addr,
                                            input int ram_words,
                                            input int scr_words);
        int a;
        a = int'(addr);
        if (a >= int'(RAM_BASE) && a < int'(RAM_BASE) + ram_words)
            return REG_RAM;
        else if (a >= int'(SCR_BASE) && a < int'(SCR_BASE) + scr_words)
            return REG_SCR;
        else if (addr == KBD_ADDR)
            return REG_KBD;
        else if (addr == SWR_ADDR)
            return REG_SWR;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/generic_fifo.sv
// Synchronous FIFO, power-of-2 depth, no fall-through. A push while full is
// accepted when a pop happens in the same cycle.
module generic_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign dout   = r_mem[r_rd];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: RAM, screen shadow, keyboard and switch registers with
// one-cycle registered read, plus a queued video write port.
module dmem_mmio
    import cpu_mem_pkg::*;
#(
    parameter int RAM_WORDS   = 16384,
    parameter int SCR_WORDS   = 8192,
    parameter int VFIFO_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              write_m,
    input  logic [ADDR_W-1:0] write_data_addr,
    input  logic [DATA_W-1:0] out_m,
    input  logic [ADDR_W-1:0] read_data_addr,
    output logic [DATA_W-1:0] in_m,
    input  logic [3:0]        SW,
    input  logic [DATA_W-1:0] kbd_code,
    input  logic              kbd_strobe,
    output logic              vid_valid,
    input  logic              vid_ready,
    output logic [12:0]       vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_overflow,
    output logic [CNT_W-1:0]  vid_drop_cnt
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);

    logic [DATA_W-1:0] r_ram    [RAM_WORDS];
    logic [DATA_W-1:0] r_shadow [SCR_WORDS];
    logic [DATA_W-1:0] r_in_m;
    logic [DATA_W-1:0] r_kbd;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop_cnt;

    region_e           w_wr_reg;
    region_e           w_rd_reg;
    logic              w_scr_push;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;
    logic [28:0]       w_din;
    logic [28:0]       w_dout;

    assign w_wr_reg   = decode_addr(write_data_addr, RAM_WORDS, SCR_WORDS);
    assign w_rd_reg   = decode_addr(read_data_addr, RAM_WORDS, SCR_WORDS);
    assign w_scr_push = write_m && (w_wr_reg == REG_SCR);
    assign w_pop      = !w_empty && vid_ready;
    // A full queue still takes the write when the head leaves in the same cycle.
    assign w_drop     = w_scr_push && w_full && !w_pop;
    assign w_din      = {13'(write_data_addr - SCR_BASE), out_m};

    assign in_m         = r_in_m;
    assign vid_valid    = !w_empty;
    assign {vid_addr, vid_data} = w_dout;
    assign vid_overflow = r_ovf;
    assign vid_drop_cnt = r_drop_cnt;

    // Memory writes; arrays are left unreset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (write_m) begin
            case (w_wr_reg)
                REG_RAM: r_ram[RAM_AW'(write_data_addr - RAM_BASE)]    <= out_m;
                REG_SCR: r_shadow[SCR_AW'(write_data_addr - SCR_BASE)] <= out_m;
                default: ;
            endcase
        end
    end

    // Registered read mux; non-blocking reads give read-before-write on collisions.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_in_m <= '0;
        end else begin
            case (w_rd_reg)
                REG_RAM: r_in_m <= r_ram[RAM_AW'(read_data_addr - RAM_BASE)];
                REG_SCR: r_in_m <= r_shadow[SCR_AW'(read_data_addr - SCR_BASE)];
                REG_KBD: r_in_m <= r_kbd;
                REG_SWR: r_in_m <= {{(DATA_W-4){1'b0}}, SW};
                default: r_in_m <= '0;
            endcase
        end
    end

    // Keyboard register captures the code on each decoder strobe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)         r_kbd <= '0;
        else if (kbd_strobe) r_kbd <= kbd_code;
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    generic_fifo #(
        .DEPTH (VFIFO_DEPTH),
        .WIDTH (29)
    ) u_vfifo (
        .clk   (clk),
        .rst_n (resetN),
        .flush (1'b0),
        .push  (w_scr_push),
        .din   (w_din),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomised + directed bench for dmem_mmio with a scoreboard-based checker.
module tb_dmem_mmio;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        write_m = 1'b0;
    logic [14:0] write_data_addr = '0;
    logic [15:0] out_m = '0;
    logic [14:0] read_data_addr = '0;
    logic [15:0] in_m;
    logic [3:0]  sw_v = '0;
    logic [15:0] kbd_code = '0;
    logic        kbd_strobe = 1'b0;
    logic        vid_valid;
    logic        vid_ready = 1'b0;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_overflow;
    logic [7:0]  vid_drop_cnt;

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_WORDS(16384), .SCR_WORDS(8192), .VFIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .resetN(resetN), .write_m(write_m), .write_data_addr(write_data_addr),
        .out_m(out_m), .read_data_addr(read_data_addr), .in_m(in_m), .SW(sw_v),
        .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .vid_valid(vid_valid),
        .vid_ready(vid_ready), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_overflow(vid_overflow), .vid_drop_cnt(vid_drop_cnt)
    );

    int npass = 0;
    int ntot  = 0;

    // reference model state
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kbd_m = '0;
    logic        ovf_m = 1'b0;
    int          cnt_m = 0;
    logic [28:0] vq[$];       // model of what the video queue holds
    logic [28:0] sb_vid[$];   // expected video handshakes, in order
    logic [15:0] rd_q[$];     // expected in_m per issued cycle
    logic [9:0]  fl_q[$];     // expected {vid_valid, overflow, drop_cnt}

    int pool[$] = '{0, 1, 2, 3, 4, 6, 7, 'h3FFF, 'h4000, 'h4001, 'h4002, 'h4003,
                    'h4004, 'h4005, 'h4006, 'h5FFF, 'h6000, 'h6001, 'h6002, 'h7FFF};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [15:0] model_rd(input int a);
        if (a < 'h4000)       return ram_m[a];
        else if (a < 'h6000)  return scr_m[a - 'h4000];
        else if (a == 'h6000) return kbd_m;
        else if (a == 'h6001) return {12'b0, sw_v};
        else                  return 16'h0000;
    endfunction

    // One cpu cycle: drive at negedge, predict what the following posedge yields.
    task automatic cyc(input bit we, input int wa, input logic [15:0] wd, input int ra,
                       input bit rdy, input bit stb = 1'b0, input logic [15:0] code = '0);
        logic [15:0] e;
        logic [28:0] ent;
        @(negedge clk);
        write_m = we; write_data_addr = 15'(wa); out_m = wd;
        read_data_addr = 15'(ra); vid_ready = rdy; kbd_strobe = stb; kbd_code = code;
        e = model_rd(ra);
        if (vq.size() > 0 && rdy) void'(vq.pop_front());
        if (we) begin
            if (wa < 'h4000) ram_m[wa] = wd;
            else if (wa < 'h6000) begin
                scr_m[wa - 'h4000] = wd;
                ent = {13'(wa - 'h4000), wd};
                if (vq.size() < DEPTH) begin
                    vq.push_back(ent);
                    sb_vid.push_back(ent);
                end else begin
                    ovf_m = 1'b1;
                    if (cnt_m < 255) cnt_m++;
                end
            end
        end
        if (stb) kbd_m = code;
        rd_q.push_back(e);
        fl_q.push_back({vq.size() > 0, ovf_m, 8'(cnt_m)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        write_m = 1'b0; kbd_strobe = 1'b0;
        resetN = 1'b0;
        vq.delete(); sb_vid.delete();
        kbd_m = '0; ovf_m = 1'b0; cnt_m = 0;
        #1;
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_in_m", in_m, 0);
        chk("rst_overflow", vid_overflow, 0);
        chk("rst_drop_cnt", vid_drop_cnt, 0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // read-data / flag monitor: after every edge with a pending expectation
    always begin
        logic [9:0] f;
        @(posedge clk);
        #1;
        if (rd_q.size() > 0) begin
            chk("in_m", in_m, rd_q.pop_front());
            f = fl_q.pop_front();
            chk("vid_valid", vid_valid, f[9]);
            chk("ovf_cnt", {vid_overflow, vid_drop_cnt}, f[8:0]);
        end
    end

    // video monitor: whenever a handshake will complete at the next edge
    always begin
        @(negedge clk);
        #1;
        if (resetN && vid_valid && vid_ready) begin
            if (sb_vid.size() == 0) begin
                ntot++;
                $display("FAIL vid_unexpected: got %h expected no entry", {vid_addr, vid_data});
            end else begin
                chk("vid_entry", {vid_addr, vid_data}, sb_vid.pop_front());
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("init_in_m", in_m, 0);
        chk("init_vid_valid", vid_valid, 0);
        chk("init_flags", {vid_overflow, vid_drop_cnt}, 0);
        @(negedge clk);
        resetN = 1'b1;

        // 1: RAM write/read, read-before-write collision
        cyc(1, 5, 16'h1234, 'h7000, 1);
        cyc(0, 0, 0, 5, 1);
        cyc(1, 5, 16'h5555, 5, 1);
        cyc(0, 0, 0, 5, 1);

        // 2: screen write appears on the video port next cycle
        cyc(1, 'h4010, 16'hFFFF, 'h7000, 1);
        cyc(0, 0, 0, 'h4010, 1);
        cyc(0, 0, 0, 'h7000, 1);

        // 3: six writes into a stalled queue of four
        for (int i = 0; i < 6; i++) cyc(1, 'h4100 + i, 16'hA000 + 16'(i), 'h7000, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 'h4100 + i, 1);

        // 4: full queue, push with simultaneous pop
        for (int i = 0; i < 4; i++) cyc(1, 'h4200 + i, 16'hB000 + 16'(i), 'h7000, 0);
        cyc(1, 'h4204, 16'hBEEF, 'h7000, 1);
        cyc(0, 0, 0, 'h4204, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 'h7000, 1);

        // 5: keyboard, switches, unmapped
        cyc(0, 0, 0, 'h6000, 1, 1, 16'h0041);
        cyc(0, 0, 0, 'h6000, 1);
        cyc(0, 0, 0, 'h6000, 1, 1, 16'h0000);
        cyc(0, 0, 0, 'h6000, 1);
        sw_v = 4'b1010;
        cyc(0, 0, 0, 'h6001, 1);
        cyc(0, 0, 0, 'h7000, 1);

        // initialise the random address pool (KBD/SWR/unmapped writes must be ignored)
        foreach (pool[i]) cyc(1, pool[i], 16'($urandom), 'h7000, 1);
        foreach (pool[i]) cyc(0, 0, 0, pool[i], 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) sw_v = 4'($urandom);
            cyc(1'($urandom), pool[$urandom_range(0, pool.size() - 1)], 16'($urandom),
                pool[$urandom_range(0, pool.size() - 1)], $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, 16'($urandom));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 'h7000, 1);

        // drop counter saturation
        for (int i = 0; i < 300; i++) cyc(1, 'h4000 + (i % 7), 16'(i), 'h7000, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 'h4003, 1);

        // 6: reset with three entries queued; shadow survives
        for (int i = 0; i < 3; i++) cyc(1, 'h4300 + i, 16'hC000 + 16'(i), 'h7000, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 'h4300 + i, 1);
        cyc(0, 0, 0, 'h6000, 1);
        cyc(0, 0, 0, 'h7000, 1);

        @(negedge clk);
        chk("vid_all_seen", sb_vid.size(), 0);
        chk("rd_all_seen", rd_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
